dbg_loader: RTL and testbench
=============================

DBG_LOADER -- requirements
Module: dbg_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, giving the inter-byte timeout in CLK cycles within one command.
REQ-002 SHALL have parameter READ_LAT, default 1, giving the CLK cycles from dbg_adr valid to dbg_di valid.
REQ-003 SHALL have parameter HOLD_ON_RESET, default 0; when 1, cpu_n_reset resets to 0.
REQ-004 CLK  input  1  sole clock, all logic on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  output  8  byte to UART transmitter.
REQ-009 tx_valid  output  1  tx_data valid, held until accepted.
REQ-010 tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready.
REQ-011 dbg_mem_op  output  1  debug port owns memory bus.
REQ-012 dbg_wren  output  4  byte write enables.
REQ-013 dbg_adr  output  32  debug address.
REQ-014 dbg_do  output  32  debug write data.
REQ-015 dbg_di  input  32  debug read data.
REQ-016 cpu_n_reset  output  1  CPU reset, 0 = CPU held.

Function
REQ-017 Opcodes SHALL be: 'W' 0x57 write, 'R' 0x52 read, 'H' 0x48 hold CPU, 'G' 0x47 release CPU; multi-byte fields little-endian.
REQ-018 FSM states SHALL be IDLE, ADDR, DATA, WRITE, RDWAIT, SEND, ACK.
REQ-019 'W' SHALL be followed by 4 address bytes (ADDR) then 4 data bytes (DATA), then one WRITE cycle with dbg_mem_op=1, dbg_wren=4'hF, dbg_adr/dbg_do stable, then ACK sending 0x4B.
REQ-020 'R' SHALL be followed by 4 address bytes, then RDWAIT for READ_LAT+1 cycles with dbg_mem_op=1, dbg_wren=0, then capture dbg_di and SEND its 4 bytes LSB first.
REQ-021 'H' SHALL drive cpu_n_reset=0 and 'G' cpu_n_reset=1 on the cycle after the opcode strobe, each followed by ACK 0x4B.
REQ-022 'W' or 'R' received while cpu_n_reset=1 SHALL be refused with reply 0x21 and no bus activity.
REQ-023 Any other byte in IDLE SHALL return reply 0x3F.
REQ-024 Outside WRITE/RDWAIT, dbg_mem_op=0 and dbg_wren=0.
REQ-025 rx_valid strobes in WRITE, RDWAIT, SEND or ACK SHALL be discarded.
REQ-026 In ADDR/DATA, TIMEOUT_CYC cycles without rx_valid SHALL return to IDLE silently with no bus write.
REQ-027 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0; next byte SHALL be presented the cycle after acceptance.
REQ-028 Byte counter SHALL be 2 bits, wrapping 3->0 on the field-completing byte.

Reset
REQ-029 On RESET: state IDLE, tx_valid=0, tx_data=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, timeout counter 0, cpu_n_reset=~HOLD_ON_RESET.
REQ-030 RESET mid-command SHALL abort immediately; partial address/data SHALL never reach the bus.

Configuration
REQ-031 Macro DBG_LOADER_READ_EN defined: 'R' implemented per REQ-020.
REQ-032 Macro DBG_LOADER_READ_EN undefined: RDWAIT/SEND logic and the dbg_di capture register are absent, and 'R' SHALL be treated per REQ-023.

Structure
REQ-033 Package dbg_loader_pkg SHALL hold the state enum, opcode constants (0x57, 0x52, 0x48, 0x47) and reply constants (0x4B, 0x21, 0x3F).
REQ-034 A single sub-module dbg_loader_tx SHALL hold the tx byte register and valid/ready handshake.

Verification
REQ-035 'H' -> cpu_n_reset=0 and reply 0x4B.
REQ-036 With CPU held: 'W',00,00,02,00,37,01,01,00 -> one cycle with dbg_adr=0x00020000, dbg_do=0x00010137, dbg_wren=4'hF, then reply 0x4B.
REQ-037 With CPU held, READ_EN defined: 'R',10,00,02,00, memory returns 0x08850513 -> replies 13,05,85,08; tx_ready held low 5 cycles with no byte lost.
REQ-038 'G' then 'W' -> cpu_n_reset=1, reply 0x21, dbg_wren stays 0.
REQ-039 'W' plus 3 bytes then silence for TIMEOUT_CYC -> IDLE, no write; next 'H' -> 0x4B.
REQ-040 RESET asserted during DATA -> all outputs at reset values; byte 0x00 then replies 0x3F.

Source files
------------

// File: rtl/dbg_loader_pkg.sv
// Shared types and byte constants for the UART debug loader.
// Holds the command FSM states, opcode/reply bytes and a little-endian byte-insert helper.
package dbg_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      WRITE,
      RDWAIT,
      SEND,
      ACK
   } state_e;

   localparam logic [7:0] OP_WRITE     = 8'h57;
   localparam logic [7:0] OP_READ      = 8'h52;
   localparam logic [7:0] OP_HOLD      = 8'h48;
   localparam logic [7:0] OP_GO        = 8'h47;

   localparam logic [7:0] RPLY_ACK     = 8'h4B;
   localparam logic [7:0] RPLY_REFUSE  = 8'h21;
   localparam logic [7:0] RPLY_UNKNOWN = 8'h3F;

   // Fields arrive least-significant byte first; idx selects the byte lane.
   function automatic logic [31:0] put_byte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      r[8*idx +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/dbg_loader_tx.sv
// Transmit byte register with valid/ready handshake toward the UART transmitter.
// A load wins over a same-cycle acceptance so the next byte follows without a gap.
module dbg_loader_tx
   import dbg_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       accept
);

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;

   assign accept   = valid_q & tx_ready;
   assign tx_data  = data_q;
   assign tx_valid = valid_q;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/dbg_loader.sv
// UART-driven debug loader: decodes write/read/hold/go commands onto a 32-bit memory bus.
// Define DBG_LOADER_READ_EN to build the 'R' read path; without it 'R' is an unknown opcode.
module dbg_loader
   import dbg_loader_pkg::*;
#(
   parameter int TIMEOUT_CYC   = 100000,
   parameter int READ_LAT      = 1,
   parameter int HOLD_ON_RESET = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        dbg_mem_op,
   output logic [3:0]  dbg_wren,
   output logic [31:0] dbg_adr,
   output logic [31:0] dbg_do,
   input  logic [31:0] dbg_di,
   output logic        cpu_n_reset
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          cpu_q, cpu_d;
   logic          mem_op_q, mem_op_d;
   logic [3:0]    wren_q, wren_d;
   logic          tx_load;
   logic [7:0]    tx_byte;
   logic          tx_accept;

`ifdef DBG_LOADER_READ_EN
   localparam int RW = $clog2(READ_LAT + 2);
   logic          is_write_q, is_write_d;
   logic [RW-1:0] rd_cnt_q, rd_cnt_d;
   logic [31:0]   rdata_q, rdata_d;
`else
   logic          unused_dbg_di;
   assign unused_dbg_di = ^dbg_di;
`endif

   assign dbg_mem_op  = mem_op_q;
   assign dbg_wren    = wren_q;
   assign dbg_adr     = adr_q;
   assign dbg_do      = wdata_q;
   assign cpu_n_reset = cpu_q;

   // Command sequencing; the timeout counter only runs while a field is being collected.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      tmo_d   = '0;
      cpu_d   = cpu_q;
      tx_load = 1'b0;
      tx_byte = RPLY_ACK;
`ifdef DBG_LOADER_READ_EN
      is_write_d = is_write_q;
      rd_cnt_d   = '0;
      rdata_d    = rdata_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               cnt_d   = 2'd0;
               tx_load = 1'b1;
               state_d = ACK;
               case (rx_data)
                  OP_HOLD: cpu_d = 1'b0;
                  OP_GO:   cpu_d = 1'b1;
                  OP_WRITE: begin
                     if (cpu_q) begin
                        tx_byte = RPLY_REFUSE;
                     end else begin
                        tx_load = 1'b0;
                        state_d = ADDR;
`ifdef DBG_LOADER_READ_EN
                        is_write_d = 1'b1;
`endif
                     end
                  end
`ifdef DBG_LOADER_READ_EN
                  OP_READ: begin
                     if (cpu_q) begin
                        tx_byte = RPLY_REFUSE;
                     end else begin
                        tx_load    = 1'b0;
                        state_d    = ADDR;
                        is_write_d = 1'b0;
                     end
                  end
`endif
                  default: tx_byte = RPLY_UNKNOWN;
               endcase
            end
         end
         ADDR: begin
            if (rx_valid) begin
               adr_d = put_byte(adr_q, cnt_q, rx_data);
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
`ifdef DBG_LOADER_READ_EN
                  state_d = is_write_q ? DATA : RDWAIT;
`else
                  state_d = DATA;
`endif
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DATA: begin
            if (rx_valid) begin
               wdata_d = put_byte(wdata_q, cnt_q, rx_data);
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = WRITE;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         WRITE: begin
            tx_load = 1'b1;
            tx_byte = RPLY_ACK;
            state_d = ACK;
         end
`ifdef DBG_LOADER_READ_EN
         // Read data is sampled on the last of READ_LAT+1 bus cycles; byte 0 goes out at once.
         RDWAIT: begin
            rd_cnt_d = rd_cnt_q + RW'(1);
            if (rd_cnt_q == RW'(READ_LAT)) begin
               rd_cnt_d = '0;
               rdata_d  = dbg_di;
               tx_load  = 1'b1;
               tx_byte  = dbg_di[7:0];
               cnt_d    = 2'd1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (tx_accept) begin
               if (cnt_q == 2'd0) begin
                  state_d = IDLE;
               end else begin
                  tx_load = 1'b1;
                  tx_byte = rdata_q[8*cnt_q +: 8];
                  cnt_d   = cnt_q + 2'd1;
               end
            end
         end
`endif
         ACK: begin
            if (tx_accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      mem_op_d = (state_d == WRITE) || (state_d == RDWAIT);
      wren_d   = (state_d == WRITE) ? 4'hF : 4'h0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         adr_q    <= '0;
         wdata_q  <= '0;
         tmo_q    <= '0;
         cpu_q    <= (HOLD_ON_RESET == 0);
         mem_op_q <= 1'b0;
         wren_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         tmo_q    <= tmo_d;
         cpu_q    <= cpu_d;
         mem_op_q <= mem_op_d;
         wren_q   <= wren_d;
      end
   end

`ifdef DBG_LOADER_READ_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         is_write_q <= 1'b1;
         rd_cnt_q   <= '0;
         rdata_q    <= '0;
      end else begin
         is_write_q <= is_write_d;
         rd_cnt_q   <= rd_cnt_d;
         rdata_q    <= rdata_d;
      end
   end
`endif

   dbg_loader_tx u_tx (
      .clk       (CLK),
      .rst       (RESET),
      .load      (tx_load),
      .load_data (tx_byte),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .accept    (tx_accept)
   );

endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: a command-level model predicts replies, bus writes and CPU reset state.
// Build with or without DBG_LOADER_READ_EN; the expected behaviour of 'R' follows the macro.
module tb_dbg_loader;

   localparam int TO = 20;
   localparam int RL = 2;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        dbg_mem_op;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr;
   logic [31:0] dbg_do;
   logic [31:0] dbg_di;
   logic        cpu_n_reset;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]  exp_tx[$];
   logic [63:0] exp_wr[$];
   logic [7:0]  pend[$];
   logic [7:0]  got_tx[$];
   logic [7:0]  cmd[$];
   logic        model_cpu = 1'b1;
   logic [31:0] last_wr_adr = '0;
   logic [31:0] last_wr_do = '0;
   logic        exp_valid_next = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;
   logic [31:0] di_pipe [RL];

   always #5 CLK = ~CLK;

   dbg_loader #(.TIMEOUT_CYC(TO), .READ_LAT(RL), .HOLD_ON_RESET(0)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .dbg_mem_op  (dbg_mem_op),
      .dbg_wren    (dbg_wren),
      .dbg_adr     (dbg_adr),
      .dbg_do      (dbg_do),
      .dbg_di      (dbg_di),
      .cpu_n_reset (cpu_n_reset)
   );

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (a == 32'h00020010) return 32'h08850513;
      return a ^ 32'hA5A50000;
   endfunction

   // Memory returns data RL cycles after the address it was given.
   always @(posedge CLK) begin
      di_pipe[0] <= memRead(dbg_adr);
      for (int i = 1; i < RL; i++) di_pipe[i] <= di_pipe[i-1];
   end
   assign dbg_di = di_pipe[RL-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic reportUnexpected(input string name, input logic [31:0] act);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected nothing", name, act);
   endtask

   // Command-level model: collects a whole command, then predicts its complete effect.
   task automatic modelRx(input logic [7:0] b);
      logic [31:0] a, d;
      if (pend.size() == 0) begin
         case (b)
            8'h48: begin model_cpu = 1'b0; exp_tx.push_back(8'h4B); end
            8'h47: begin model_cpu = 1'b1; exp_tx.push_back(8'h4B); end
            8'h57: if (model_cpu) exp_tx.push_back(8'h21); else pend.push_back(b);
`ifdef DBG_LOADER_READ_EN
            8'h52: if (model_cpu) exp_tx.push_back(8'h21); else pend.push_back(b);
`endif
            default: exp_tx.push_back(8'h3F);
         endcase
      end else begin
         pend.push_back(b);
         if (pend.size() >= 5) begin
            a = {pend[4], pend[3], pend[2], pend[1]};
            if (pend[0] == 8'h52) begin
               d = memRead(a);
               exp_tx.push_back(d[7:0]);
               exp_tx.push_back(d[15:8]);
               exp_tx.push_back(d[23:16]);
               exp_tx.push_back(d[31:24]);
               pend.delete();
            end else if (pend.size() == 9) begin
               d = {pend[8], pend[7], pend[6], pend[5]};
               exp_wr.push_back({a, d});
               exp_tx.push_back(8'h4B);
               pend.delete();
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit track);
      @(posedge CLK);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge CLK);
      #1 rx_valid = 1'b0;
      if (track) modelRx(b);
   endtask

   task automatic sendCmd(input logic [7:0] q[$]);
      foreach (q[i]) begin
         applyStimulus(q[i], 1'b1);
         repeat (2) @(posedge CLK);
      end
   endtask

   task automatic waitDrain();
      int remaining;
      for (int i = 0; i < 200; i++) begin
         if (exp_tx.size() == 0 && exp_wr.size() == 0 && !tx_valid) break;
         @(posedge CLK);
      end
      remaining = exp_tx.size() + exp_wr.size();
      checkOutput("drain_pending", remaining, 0);
      repeat (2) @(posedge CLK);
   endtask

   // Per-cycle comparison of every observable output against the model.
   always @(negedge CLK) begin
      logic [63:0] e;
      if (RESET) begin
         prev_stall = 1'b0;
         exp_valid_next = 1'b0;
      end else begin
         if (exp_valid_next) checkOutput("next_byte_presented", tx_valid, 1);
         exp_valid_next = 1'b0;
         if (prev_stall) begin
            checkOutput("tx_hold_valid", tx_valid, 1);
            checkOutput("tx_hold_data", tx_data, prev_data);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (tx_valid && tx_ready) begin
            got_tx.push_back(tx_data);
            if (exp_tx.size() == 0) begin
               reportUnexpected("unexpected_tx", tx_data);
            end else begin
               checkOutput("tx_byte", tx_data, exp_tx.pop_front());
               if (exp_tx.size() > 0) exp_valid_next = 1'b1;
            end
         end
         if (dbg_mem_op) begin
            if (dbg_wren == 4'hF) begin
               if (exp_wr.size() == 0) begin
                  reportUnexpected("unexpected_write", dbg_adr);
               end else begin
                  e = exp_wr.pop_front();
                  checkOutput("write_adr", dbg_adr, e[63:32]);
                  checkOutput("write_do", dbg_do, e[31:0]);
                  last_wr_adr = dbg_adr;
                  last_wr_do  = dbg_do;
               end
            end else begin
               checkOutput("read_wren", dbg_wren, 0);
`ifndef DBG_LOADER_READ_EN
               reportUnexpected("read_cycle_without_feature", dbg_adr);
`endif
            end
         end else begin
            checkOutput("idle_wren", dbg_wren, 0);
         end
         checkOutput("cpu_n_reset", cpu_n_reset, model_cpu);
      end
   end

   initial begin
      int n;
      bit seen;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_mem_op", dbg_mem_op, 0);
      checkOutput("rst_wren", dbg_wren, 0);
      checkOutput("rst_adr", dbg_adr, 0);
      checkOutput("rst_do", dbg_do, 0);
      checkOutput("rst_cpu_n_reset", cpu_n_reset, 1);
      RESET = 1'b0;
      repeat (2) @(posedge CLK);

      cmd = {8'hAA};
      sendCmd(cmd);
      waitDrain();
      checkOutput("unknown_reply", got_tx[got_tx.size()-1], 8'h3F);

      cmd = {8'h48};
      sendCmd(cmd);
      waitDrain();
      checkOutput("hold_reply", got_tx[got_tx.size()-1], 8'h4B);
      checkOutput("hold_cpu", cpu_n_reset, 0);

      cmd = {8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h37, 8'h01, 8'h01, 8'h00};
      sendCmd(cmd);
      waitDrain();
      checkOutput("w1_adr_literal", last_wr_adr, 32'h00020000);
      checkOutput("w1_do_literal", last_wr_do, 32'h00010137);
      checkOutput("w1_reply", got_tx[got_tx.size()-1], 8'h4B);

      // A byte arriving while a reply is pending must be dropped.
      tx_ready = 1'b0;
      applyStimulus(8'h48, 1'b1);
      repeat (2) @(posedge CLK);
      applyStimulus(8'h57, 1'b0);
      repeat (2) @(posedge CLK);
      #1 tx_ready = 1'b1;
      waitDrain();

      cmd = {8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
      sendCmd(cmd);
      waitDrain();
      checkOutput("w2_adr_literal", last_wr_adr, 32'h12345678);
      checkOutput("w2_do_literal", last_wr_do, 32'hCAFEF00D);

`ifdef DBG_LOADER_READ_EN
      tx_ready = 1'b0;
      cmd = {8'h52, 8'h10, 8'h00, 8'h02, 8'h00};
      sendCmd(cmd);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx_valid) begin seen = 1'b1; break; end
         @(posedge CLK);
      end
      checkOutput("read_reply_start", seen, 1);
      repeat (5) @(posedge CLK);
      #1 tx_ready = 1'b1;
      waitDrain();
      n = got_tx.size();
      checkOutput("read_bytes_literal",
                  (n >= 4) ? {got_tx[n-1], got_tx[n-2], got_tx[n-3], got_tx[n-4]} : 32'h0,
                  32'h08850513);
`else
      cmd = {8'h52};
      sendCmd(cmd);
      waitDrain();
      checkOutput("read_disabled_reply", got_tx[got_tx.size()-1], 8'h3F);
`endif

      // Partial write followed by silence longer than the timeout.
      cmd = {8'h57, 8'h01, 8'h02, 8'h03};
      sendCmd(cmd);
      repeat (TO + 5) @(posedge CLK);
      pend.delete();
      cmd = {8'h48};
      sendCmd(cmd);
      waitDrain();
      checkOutput("timeout_then_hold", got_tx[got_tx.size()-1], 8'h4B);

      cmd = {8'h47};
      sendCmd(cmd);
      waitDrain();
      checkOutput("go_cpu", cpu_n_reset, 1);
      cmd = {8'h57};
      sendCmd(cmd);
      waitDrain();
      checkOutput("refuse_reply", got_tx[got_tx.size()-1], 8'h21);
`ifdef DBG_LOADER_READ_EN
      cmd = {8'h52};
      sendCmd(cmd);
      waitDrain();
      checkOutput("refuse_read_reply", got_tx[got_tx.size()-1], 8'h21);
`endif

      // Reset in the middle of the data field.
      cmd = {8'h48};
      sendCmd(cmd);
      waitDrain();
      cmd = {8'h57, 8'h44, 8'h33, 8'h22, 8'h11, 8'h99, 8'h88};
      sendCmd(cmd);
      @(posedge CLK);
      #1 RESET = 1'b1;
      #1;
      checkOutput("mid_rst_tx_valid", tx_valid, 0);
      checkOutput("mid_rst_tx_data", tx_data, 0);
      checkOutput("mid_rst_mem_op", dbg_mem_op, 0);
      checkOutput("mid_rst_wren", dbg_wren, 0);
      checkOutput("mid_rst_adr", dbg_adr, 0);
      checkOutput("mid_rst_do", dbg_do, 0);
      checkOutput("mid_rst_cpu", cpu_n_reset, 1);
      pend.delete();
      exp_tx.delete();
      exp_wr.delete();
      model_cpu = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      cmd = {8'h00};
      sendCmd(cmd);
      waitDrain();
      checkOutput("post_rst_reply", got_tx[got_tx.size()-1], 8'h3F);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
